// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected layer blocks: FSM state encoding,
// default Q-format and size parameters, and the common round/saturate function.
// Optional feature macro used by this block family: FC_RELU_EN.
package fc_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_IN = 3'd1,
    MAC     = 3'd2,
    BIAS    = 3'd3,
    ROUND   = 3'd4,
    OUT     = 3'd5,
    DONE    = 3'd6
  } fc_state_t;

  localparam int FC_DATA_W  = 16;
  localparam int FC_FRAC_W  = 8;
  localparam int FC_NUM_IN  = 5;
  localparam int FC_NUM_OUT = 3;
  localparam int FC_ACC_W   = 40;

  // Width of the internal working value of sat_round; callers sign-extend
  // their accumulator into it so one function serves every ACC_W.
  localparam int FC_WIDE_W  = 128;

  // Round half up at bit frac_w-1, shift right arithmetically by frac_w,
  // then clamp to the signed data_w range. The result is sign-extended to
  // 64 bits; callers keep the low data_w bits.
  function automatic logic signed [63:0] sat_round(
    input logic signed [FC_WIDE_W-1:0] acc,
    input int                          frac_w,
    input int                          data_w
  );
    logic signed [FC_WIDE_W-1:0] half;
    logic signed [FC_WIDE_W-1:0] rnd;
    logic signed [FC_WIDE_W-1:0] hi;
    logic signed [FC_WIDE_W-1:0] lo;
    half = (frac_w > 0) ? (128'sd1 <<< (frac_w - 1)) : 128'sd0;
    rnd  = (acc + half) >>> frac_w;
    hi   = (128'sd1 <<< (data_w - 1)) - 128'sd1;
    lo   = -(128'sd1 <<< (data_w - 1));
    if (rnd > hi) begin
      rnd = hi;
    end else if (rnd < lo) begin
      rnd = lo;
    end
    return 64'(rnd);
  endfunction

endpackage

// File: rtl/fc_mac_sat.sv
// Signed multiply-accumulate with bias add and a registered round/saturate
// output stage. Defining FC_RELU_EN clamps negative results to zero in the
// same output register, so latency does not change.
module fc_mac_sat import fc_pkg::*; #(
  parameter int DATA_W = FC_DATA_W,
  parameter int FRAC_W = FC_FRAC_W,
  parameter int ACC_W  = FC_ACC_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     acc_en,
  input  logic                     bias_en,
  input  logic                     round_en,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [DATA_W-1:0] w,
  input  logic signed [DATA_W-1:0] bias,
  output logic signed [DATA_W-1:0] y
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    bias_ext;
  logic signed [ACC_W-1:0]    acc_p0;
  logic signed [63:0]         rs;
  logic signed [DATA_W-1:0]   y_next;
  logic signed [DATA_W-1:0]   res_p1;

  // Full-precision product, then sign extension into the accumulator width;
  // the bias is aligned to the product's 2*FRAC_W fractional point.
  assign prod     = x * w;
  assign prod_ext = ACC_W'(prod);
  assign bias_ext = ACC_W'(bias) <<< FRAC_W;
  assign rs       = sat_round(FC_WIDE_W'(acc_p0), FRAC_W, DATA_W);

  // Output value of the round stage, with optional rectification.
  always_comb begin
    y_next = DATA_W'(rs);
`ifdef FC_RELU_EN
    if (rs < 0) begin
      y_next = '0;
    end
`else
`endif
  end

  // Accumulator and output register; clear takes priority so a new node
  // always starts from zero, and the output only moves in the round stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_p0 <= '0;
      res_p1 <= '0;
    end else begin
      if (clr) begin
        acc_p0 <= '0;
      end else if (acc_en) begin
        acc_p0 <= acc_p0 + prod_ext;
      end else if (bias_en) begin
        acc_p0 <= acc_p0 + bias_ext;
      end
      if (round_en) begin
        res_p1 <= y_next;
      end
    end
  end

  assign y = res_p1;

endmodule

// File: rtl/fc_layer_stream.sv
// Streaming fully-connected layer: buffers NUM_IN inputs, then for each of the
// NUM_OUT nodes consumes a weight row and a bias through one MAC, rounds,
// saturates and emits one word. Optional ReLU on the output: FC_RELU_EN.
module fc_layer_stream import fc_pkg::*; #(
  parameter int DATA_W  = FC_DATA_W,
  parameter int FRAC_W  = FC_FRAC_W,
  parameter int NUM_IN  = FC_NUM_IN,
  parameter int NUM_OUT = FC_NUM_OUT,
  parameter int ACC_W   = FC_ACC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [DATA_W-1:0] w_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [DATA_W-1:0] b_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  localparam int IW = (NUM_IN  > 1) ? $clog2(NUM_IN)  : 1;
  localparam int OW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam logic [IW-1:0] IN_LAST  = IW'(NUM_IN - 1);
  localparam logic [OW-1:0] OUT_LAST = OW'(NUM_OUT - 1);

  fc_state_t                state;
  logic [IW-1:0]            in_cnt;
  logic [OW-1:0]            out_cnt;
  logic signed [DATA_W-1:0] xbuf [NUM_IN];

  logic                     mac_clr;
  logic                     mac_acc_en;
  logic                     mac_bias_en;
  logic                     mac_round_en;
  logic signed [DATA_W-1:0] x_sel;
  logic signed [DATA_W-1:0] w_s;
  logic signed [DATA_W-1:0] b_s;
  logic signed [DATA_W-1:0] mac_y;

  // Datapath controls follow the handshakes directly so stalls hold the
  // accumulator; it is cleared at pass start and after each emitted node.
  assign mac_clr      = ((state == IDLE) && start) || ((state == OUT) && out_ready);
  assign mac_acc_en   = w_ready && w_valid;
  assign mac_bias_en  = b_ready && b_valid;
  assign mac_round_en = (state == ROUND);
  assign x_sel        = xbuf[in_cnt];
  assign w_s          = w_data;
  assign b_s          = b_data;

  fc_mac_sat #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (mac_clr),
    .acc_en   (mac_acc_en),
    .bias_en  (mac_bias_en),
    .round_en (mac_round_en),
    .x        (x_sel),
    .w        (w_s),
    .bias     (b_s),
    .y        (mac_y)
  );

  assign out_data = mac_y;

  // Layer sequencer: state, node/input counters, input buffer and all
  // registered handshake/status outputs, updated together on each transition.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_cnt    <= '0;
      out_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      in_ready  <= 1'b0;
      w_ready   <= 1'b0;
      b_ready   <= 1'b0;
      out_valid <= 1'b0;
      for (int i = 0; i < NUM_IN; i++) begin
        xbuf[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD_IN;
            busy     <= 1'b1;
            in_ready <= 1'b1;
            in_cnt   <= '0;
            out_cnt  <= '0;
          end
        end
        LOAD_IN: begin
          if (in_valid) begin
            xbuf[in_cnt] <= in_data;
            if (in_cnt == IN_LAST) begin
              in_cnt   <= '0;
              in_ready <= 1'b0;
              w_ready  <= 1'b1;
              state    <= MAC;
            end else begin
              in_cnt <= in_cnt + 1'b1;
            end
          end
        end
        MAC: begin
          if (w_valid) begin
            if (in_cnt == IN_LAST) begin
              in_cnt  <= '0;
              w_ready <= 1'b0;
              b_ready <= 1'b1;
              state   <= BIAS;
            end else begin
              in_cnt <= in_cnt + 1'b1;
            end
          end
        end
        BIAS: begin
          if (b_valid) begin
            b_ready <= 1'b0;
            state   <= ROUND;
          end
        end
        ROUND: begin
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_cnt == OUT_LAST) begin
              out_cnt <= '0;
              done    <= 1'b1;
              state   <= DONE;
            end else begin
              out_cnt <= out_cnt + 1'b1;
              w_ready <= 1'b1;
              state   <= MAC;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy      <= 1'b0;
          in_ready  <= 1'b0;
          w_ready   <= 1'b0;
          b_ready   <= 1'b0;
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fc_layer_stream.sv
// Scoreboard bench for fc_layer_stream at default parameters. Expected words
// are queued when a pass is launched and popped as the DUT emits them.
// Build with FC_RELU_EN defined to check the rectified variant.
module tb_fc_layer_stream;

  localparam int DATA_W  = 16;
  localparam int FRAC_W  = 8;
  localparam int NUM_IN  = 5;
  localparam int NUM_OUT = 3;
  localparam int ACC_W   = 40;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              busy;
  logic              done;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              w_valid = 1'b0;
  logic              w_ready;
  logic [DATA_W-1:0] w_data = '0;
  logic              b_valid = 1'b0;
  logic              b_ready;
  logic [DATA_W-1:0] b_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;

  fc_layer_stream #(
    .DATA_W  (DATA_W),
    .FRAC_W  (FRAC_W),
    .NUM_IN  (NUM_IN),
    .NUM_OUT (NUM_OUT),
    .ACC_W   (ACC_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_data    (w_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_data    (b_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int done_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] tx    [NUM_IN];
  logic [DATA_W-1:0] tw    [NUM_IN*NUM_OUT];
  logic [DATA_W-1:0] tbias [NUM_OUT];
  logic [DATA_W-1:0] expq  [$];

  int t0;
  int rise_per [NUM_OUT];
  int hs_per   [NUM_OUT];
  bit gaps = 1'b0;
  bit pulse_start = 1'b0;

  // Reference arithmetic: exact sum, bias at 2*FRAC_W, round half up, clamp.
  function automatic logic [DATA_W-1:0] model(input int j);
    longint acc;
    longint r;
    logic [DATA_W-1:0] res;
    acc = 0;
    for (int i = 0; i < NUM_IN; i++) begin
      acc += longint'($signed(tx[i])) * longint'($signed(tw[j*NUM_IN+i]));
    end
    acc += longint'($signed(tbias[j])) * 256;
    r = (acc + 128) >>> 8;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
`ifdef FC_RELU_EN
    if (r < 0) r = 0;
`endif
    res = r[DATA_W-1:0];
    return res;
  endfunction

  task automatic fill(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] w,
                      input logic [DATA_W-1:0] b);
    for (int i = 0; i < NUM_IN; i++) tx[i] = x;
    for (int i = 0; i < NUM_IN*NUM_OUT; i++) tw[i] = w;
    for (int i = 0; i < NUM_OUT; i++) tbias[i] = b;
  endtask

  task automatic set_valid(input int ch, input logic v);
    case (ch)
      0:       in_valid = v;
      1:       w_valid  = v;
      default: b_valid  = v;
    endcase
  endtask

  // Streams n words on channel ch (0 in, 1 weight, 2 bias), optionally with gaps.
  task automatic feed(input int ch, input int n);
    int  wait_n;
    bit  ok;
    for (int k = 0; k < n; k++) begin
      if (gaps) begin
        set_valid(ch, 1'b0);
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
      end
      case (ch)
        0:       begin in_valid = 1'b1; in_data = tx[k];    end
        1:       begin w_valid  = 1'b1; w_data  = tw[k];    end
        default: begin b_valid  = 1'b1; b_data  = tbias[k]; end
      endcase
      wait_n = 0;
      ok = 1'b0;
      while (!ok) begin
        @(negedge clk);
        case (ch)
          0:       ok = (in_ready === 1'b1);
          1:       ok = (w_ready  === 1'b1);
          default: ok = (b_ready  === 1'b1);
        endcase
        if (!ok) begin
          wait_n++;
          if (wait_n > 500) begin
            total++; bad++;
            $display("FAIL feed_timeout ch=%0d word=%0d: ready stayed low 500 cycles, required a handshake", ch, k);
            set_valid(ch, 1'b0);
            return;
          end
        end
      end
      @(posedge clk); #1;
    end
    set_valid(ch, 1'b0);
  endtask

  // Accepts NUM_OUT words, checks them against the queue and checks that a
  // stalled output holds; optionally refuses the first output for 10 cycles.
  task automatic consume(input bit hold_first);
    int got = 0;
    int budget = 0;
    int stall = 0;
    bit prev_stall = 1'b0;
    bit prev_v = 1'b0;
    bit nr;
    logic [DATA_W-1:0] prev_d = '0;
    logic [DATA_W-1:0] e;
    out_ready = !hold_first;
    while (got < NUM_OUT) begin
      @(negedge clk);
      budget++;
      if (budget > 2000) begin
        total++; bad++;
        $display("FAIL out_timeout: got %0d outputs, required %0d", got, NUM_OUT);
        out_ready = 1'b0;
        return;
      end
      if (prev_stall) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== prev_d) begin
          bad++;
          $display("FAIL out_hold: valid=%b data=%h, required valid=1 data=%h", out_valid, out_data, prev_d);
        end
      end
      if (out_valid === 1'b1 && !prev_v) rise_per[got] = cyc - t0;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        e = expq.pop_front();
        total++;
        if (out_data !== e) begin
          bad++;
          $display("FAIL out_data[%0d]: got %h, required %h", got, out_data, e);
        end
        hs_per[got] = cyc - t0;
        got++;
      end
      prev_stall = (out_valid === 1'b1) && (out_ready !== 1'b1);
      prev_v     = (out_valid === 1'b1);
      prev_d     = out_data;
      if (hold_first) begin
        if (out_valid === 1'b1) stall++;
        nr = (stall >= 10) ? ($urandom_range(0, 3) != 0) : 1'b0;
      end else begin
        nr = 1'b1;
      end
      @(posedge clk); #1;
      out_ready = nr;
    end
    out_ready = 1'b0;
    @(negedge clk);
    total++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL done_pulse: done=%b busy=%b, required done=1 busy=1", done, busy);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL after_done: done=%b busy=%b, required done=0 busy=0", done, busy);
    end
  endtask

  task automatic pulser();
    if (pulse_start) begin
      repeat (3) begin @(posedge clk); #1; end
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (8) begin @(posedge clk); #1; end
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  // Launches one pass; cst_en queues the fixed word cst for every node,
  // otherwise the reference model result per node.
  task automatic run_pass(input bit hold_first, input bit cst_en, input logic [DATA_W-1:0] cst);
    int d0;
    for (int j = 0; j < NUM_OUT; j++) expq.push_back(cst_en ? cst : model(j));
    d0 = done_cnt;
    start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    fork
      feed(0, NUM_IN);
      feed(1, NUM_IN*NUM_OUT);
      feed(2, NUM_OUT);
      consume(hold_first);
      pulser();
    join
    total++;
    if (expq.size() != 0 || done_cnt - d0 != 1) begin
      bad++;
      $display("FAIL pass_end: queue left=%0d done pulses=%0d, required 0 and 1", expq.size(), done_cnt - d0);
    end
    expq.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    total++;
    if ({busy, done, in_ready, w_ready, b_ready, out_valid} !== 6'b0 || out_data !== '0) begin
      bad++;
      $display("FAIL reset_state: flags=%b data=%h, required 000000 and 0000",
               {busy, done, in_ready, w_ready, b_ready, out_valid}, out_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: busy=%b in_ready=%b, required 0 0", busy, in_ready);
    end
  endtask

  task automatic test_basic();
    gaps = 1'b0;
    fill(16'h0100, 16'h0080, 16'h0040);
    run_pass(1'b0, 1'b1, 16'h02C0);
    total++;
    if (rise_per[0] != 2*NUM_IN+3) begin
      bad++;
      $display("FAIL first_latency: got cycle %0d, required %0d", rise_per[0], 2*NUM_IN+3);
    end
    for (int j = 1; j < NUM_OUT; j++) begin
      total++;
      if (rise_per[j] - hs_per[j-1] != NUM_IN+3) begin
        bad++;
        $display("FAIL node_spacing[%0d]: got %0d, required %0d", j, rise_per[j] - hs_per[j-1], NUM_IN+3);
      end
    end
  endtask

  task automatic test_saturation();
    gaps = 1'b0;
    fill(16'h7FFF, 16'h7FFF, 16'h7FFF);
    run_pass(1'b0, 1'b1, 16'h7FFF);
    fill(16'h7FFF, 16'h8000, 16'h7FFF);
`ifdef FC_RELU_EN
    run_pass(1'b0, 1'b1, 16'h0000);
`else
    run_pass(1'b0, 1'b1, 16'h8000);
`endif
  endtask

  task automatic test_negative();
    gaps = 1'b0;
    fill(16'h0100, 16'hFF80, 16'h0000);
`ifdef FC_RELU_EN
    run_pass(1'b0, 1'b1, 16'h0000);
`else
    run_pass(1'b0, 1'b1, 16'hFD80);
`endif
  endtask

  task automatic test_stall();
    gaps = 1'b1;
    for (int i = 0; i < NUM_IN; i++) tx[i] = DATA_W'($urandom);
    for (int i = 0; i < NUM_IN*NUM_OUT; i++) tw[i] = DATA_W'($urandom_range(0, 16'h03FF)) - 16'h0200;
    for (int i = 0; i < NUM_OUT; i++) tbias[i] = DATA_W'($urandom);
    run_pass(1'b1, 1'b0, '0);
    gaps = 1'b0;
  endtask

  task automatic test_mid_reset();
    gaps = 1'b0;
    fill(16'h0100, 16'h0080, 16'h0040);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    feed(0, NUM_IN);
    feed(1, 2);
    w_valid = 1'b1;
    w_data  = tw[2];
    rst_n   = 1'b0;
    @(posedge clk); #1;
    rst_n   = 1'b1;
    w_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, done, in_ready, w_ready, b_ready, out_valid} !== 6'b0 || out_data !== '0) begin
      bad++;
      $display("FAIL mid_reset_state: flags=%b data=%h, required 000000 and 0000",
               {busy, done, in_ready, w_ready, b_ready, out_valid}, out_data);
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_idle: busy=%b, required 0", busy);
    end
    run_pass(1'b0, 1'b1, 16'h02C0);
  endtask

  task automatic test_start_busy();
    bit stray;
    gaps = 1'b0;
    pulse_start = 1'b1;
    fill(16'h0180, 16'h0001, 16'h0000);
    // 5 * 1.5 * (1/256) is 7.5 LSB; half-up rounding gives 8.
    run_pass(1'b0, 1'b1, 16'h0008);
    pulse_start = 1'b0;
    stray = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (busy !== 1'b0 || in_ready !== 1'b0) stray = 1'b1;
    end
    total++;
    if (stray) begin
      bad++;
      $display("FAIL start_ignored: extra pass started, required busy=0 after done");
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_negative();
    test_stall();
    test_mid_reset();
    test_start_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
